serializador_n: RTL and testbench

- Transmit side for N-bit words held in registradores_N.
- Accepts one parallel word through a valid/ready handshake and captures it in an internal register.
- Shifts the word out on a single line as a framed serial stream: start bit, N data bits LSB first, stop bit.
- Sits between the game datapath and any single-wire consumer, such as a serial link to the host or a debug channel.

---
 rtl/serializador_n.sv | 145 ++++++++++++++
 tb/tb_serializador_n.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serializador_n.sv
// Framed serial transmitter: accepts one N-bit word by valid/ready and sends
// start bit, N data bits LSB first and stop bit, each held for DIV clock cycles.
module serializador_n #(
    parameter int unsigned N   = 4,
    parameter int unsigned DIV = 4,
    localparam int unsigned BW = ($clog2(N + 2) > 1) ? $clog2(N + 2) : 1,
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          dados_valid,
    input  logic [N-1:0]  dados,
    output logic          pronto,
    output logic          saida_serial,
    output logic          ocupado,
    output logic          fim,
    output logic [BW-1:0] bit_atual
);

    typedef enum logic [2:0] {
        S_INICIAL = 3'd0,
        S_START   = 3'd1,
        S_DADOS   = 3'd2,
        S_STOP    = 3'd3,
        S_FIM     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          pronto_q, pronto_d;
    logic          saida_q, saida_d;
    logic          ocupado_q, ocupado_d;
    logic          fim_q, fim_d;
    logic          div_tc;

    // Last cycle of the current serial bit; always true when DIV == 1.
    assign div_tc = (div_q == DW'(DIV - 1));

    // State, datapath and registered outputs; clear wins over everything.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q   <= S_INICIAL;
            shift_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            pronto_q  <= 1'b1;
            saida_q   <= 1'b1;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            pronto_q  <= pronto_d;
            saida_q   <= saida_d;
            ocupado_q <= ocupado_d;
            fim_q     <= fim_d;
        end
    end

    // Next-state logic and next values of the output registers.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        div_d     = div_q;
        pronto_d  = 1'b0;
        saida_d   = 1'b1;
        ocupado_d = 1'b0;
        fim_d     = 1'b0;

        case (state_q)
            S_INICIAL: begin
                bit_d = '0;
                div_d = '0;
                if (dados_valid) begin
                    shift_d = dados;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_tc) begin
                    div_d   = '0;
                    bit_d   = BW'(1);
                    state_d = S_DADOS;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DADOS: begin
                if (div_tc) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(N)) begin
                        state_d = S_STOP;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_STOP: begin
                if (div_tc) begin
                    div_d   = '0;
                    state_d = S_FIM;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_FIM: begin
                bit_d   = '0;
                state_d = S_INICIAL;
            end
            default: begin
                state_d = S_INICIAL;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it.
        case (state_d)
            S_INICIAL: pronto_d = 1'b1;
            S_START: begin
                saida_d   = 1'b0;
                ocupado_d = 1'b1;
            end
            S_DADOS: begin
                saida_d   = shift_d[0];
                ocupado_d = 1'b1;
            end
            S_STOP:    ocupado_d = 1'b1;
            S_FIM:     fim_d     = 1'b1;
            default:   pronto_d  = 1'b0;
        endcase
    end

    assign pronto       = pronto_q;
    assign saida_serial = saida_q;
    assign ocupado      = ocupado_q;
    assign fim          = fim_q;
    assign bit_atual    = bit_q;

endmodule

// File: tb/tb_serializador_n.sv
// Bench for serializador_n: stimulus queues hand-written expected frames, a
// negedge monitor pops one whenever a frame appears and checks it cycle by cycle.
module tb_serializador_n;

    typedef struct {
        logic [15:0] frame;     // line value per bit slot: start, data LSB first, stop
        int          n;
        int          div;
        int          abort_at;  // monitor cycle at which reset takes effect, -1 none
        int          gap;       // required cycles since previous fim, -1 don't care
    } exp_t;

    logic       clock;
    logic       clear;
    logic       valid;
    logic [7:0] dados;
    logic       sel;

    logic       valid4, valid8;
    logic [3:0] dados4;
    logic [7:0] dados8;
    logic       pronto4, saida4, ocup4, fim4;
    logic [2:0] bit4;
    logic       pronto8, saida8, ocup8, fim8;
    logic [3:0] bit8;

    logic       mon_pr, mon_line, mon_ocup, mon_fim;
    int         mon_bit;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_fim = -100;
    int         frame_id = 0;

    serializador_n #(.N(4), .DIV(4)) dut4 (
        .clock(clock), .clear(clear), .dados_valid(valid4), .dados(dados4),
        .pronto(pronto4), .saida_serial(saida4), .ocupado(ocup4), .fim(fim4),
        .bit_atual(bit4)
    );

    serializador_n #(.N(8), .DIV(1)) dut8 (
        .clock(clock), .clear(clear), .dados_valid(valid8), .dados(dados8),
        .pronto(pronto8), .saida_serial(saida8), .ocupado(ocup8), .fim(fim8),
        .bit_atual(bit8)
    );

    always #5 clock = ~clock;

    always_comb begin
        valid4   = sel ? 1'b0 : valid;
        valid8   = sel ? valid : 1'b0;
        dados4   = dados[3:0];
        dados8   = dados;
        mon_pr   = sel ? pronto8 : pronto4;
        mon_line = sel ? saida8 : saida4;
        mon_ocup = sel ? ocup8 : ocup4;
        mon_fim  = sel ? fim8 : fim4;
        mon_bit  = sel ? int'(bit8) : int'(bit4);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Walks one frame window starting at its first START cycle.
    task automatic run_frame(input exp_t e);
        int fl;
        int ml, mb, mo, mp, mf;
        int b;
        int eb;
        logic el, eo, ep, ef;
        fl = (e.n + 2) * e.div;
        ml = 0; mb = 0; mo = 0; mp = 0; mf = 0;
        frame_id++;
        if (e.gap >= 0)
            chk($sformatf("frame %0d gap after previous fim", frame_id), cyc - last_fim, e.gap);
        for (int c = 0; c <= fl + 1; c++) begin
            if (c > 0) begin
                @(negedge clock);
                cyc++;
            end
            if (e.abort_at >= 0 && c >= e.abort_at) begin
                el = 1'b1; eb = 0; eo = 1'b0; ep = 1'b1; ef = 1'b0;
            end else if (c < fl) begin
                b  = c / e.div;
                el = e.frame[b]; eb = b; eo = 1'b1; ep = 1'b0; ef = 1'b0;
            end else if (c == fl) begin
                el = 1'b1; eb = -1; eo = 1'b0; ep = 1'b0; ef = 1'b1;
                last_fim = cyc;
            end else begin
                el = 1'b1; eb = 0; eo = 1'b0; ep = 1'b1; ef = 1'b0;
            end
            if (mon_line !== el) ml++;
            if (eb >= 0 && mon_bit !== eb) mb++;
            if (mon_ocup !== eo) mo++;
            if (mon_pr !== ep) mp++;
            if (mon_fim !== ef) mf++;
        end
        chk($sformatf("frame %0d saida_serial bad cycles", frame_id), ml, 0);
        chk($sformatf("frame %0d bit_atual bad cycles", frame_id), mb, 0);
        chk($sformatf("frame %0d ocupado bad cycles", frame_id), mo, 0);
        chk($sformatf("frame %0d pronto bad cycles", frame_id), mp, 0);
        chk($sformatf("frame %0d fim bad cycles", frame_id), mf, 0);
    endtask

    // Monitor: a rising ocupado marks the first START cycle of a frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (mon_ocup === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected frame started", 1, 0);
                    while (mon_ocup === 1'b1) begin
                        @(negedge clock);
                        cyc++;
                    end
                end else begin
                    e = sb_q.pop_front();
                    run_frame(e);
                end
            end
        end
    end

    task automatic push(input logic [15:0] frame, input int n, input int div,
                        input int abort_at, input int gap);
        exp_t e;
        e.frame = frame; e.n = n; e.div = div; e.abort_at = abort_at; e.gap = gap;
        sb_q.push_back(e);
    endtask

    // Holds valid until the DUT shows pronto before an edge; returns #1 after it.
    task automatic send(input logic [7:0] w);
        bit acc;
        acc   = 1'b0;
        valid = 1'b1;
        dados = w;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clock);
            if (mon_pr === 1'b1) acc = 1'b1;
            @(posedge clock);
            #1;
        end
        chk("handshake accepted", int'(acc), 1);
    endtask

    initial begin
        clock = 1'b0;
        clear = 1'b0;
        valid = 1'b1;
        dados = 8'hFF;
        sel   = 1'b0;

        // Reset held with dados_valid high.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset pronto", int'(pronto4), 1);
        chk("reset saida_serial", int'(saida4), 1);
        chk("reset ocupado", int'(ocup4), 0);
        chk("reset fim", int'(fim4), 0);
        chk("reset bit_atual", int'(bit4), 0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // 4'b1011, with a zero word offered while the data bits go out.
        push(16'b1_1011_0, 4, 4, -1, -1);
        send(8'h0B);
        valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        valid = 1'b1;
        dados = 8'h00;
        repeat (6) @(posedge clock);
        #1;
        valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;

        // Back-to-back 4'hA then 4'h5 with valid held high.
        push(16'b1_1010_0, 4, 4, -1, -1);
        push(16'b1_0101_0, 4, 4, -1, 2);
        send(8'h0A);
        send(8'h05);
        valid = 1'b0;
        repeat (35) @(posedge clock);
        #1;

        // Reset during data bit 2 of 4'h6.
        push(16'b1_0110_0, 4, 4, 10, -1);
        send(8'h06);
        valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        clear = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b1;
        repeat (30) @(posedge clock);
        #1;

        // N=8, DIV=1 instance, 8'h81.
        sel = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        push(16'b1_10000001_0, 8, 1, -1, -1);
        send(8'h81);
        valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;

        chk("scoreboard drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
